// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: bundles the icache/dcache request side and the L2 cache side of the
// L2 port arbiter.
//   slave  - arbiter view: takes requests and L2 status, drives grants, L2 request, routing.
//   master - environment view (cache controllers + L2 model): the mirror image.
interface l2_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // requester side
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_rw;
    logic              ic_gnt;
    logic              dc_gnt;
    logic              ic_rdy;
    logic              dc_rdy;
    logic              ic_done;
    logic              dc_done;
    // L2 side
    logic              l2_busy;
    logic              l2_rdy;
    logic              l2_complete;
    logic              l2_req;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_cache_rw;
    logic              arb_err;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_rdy, l2_complete,
        output ic_gnt, dc_gnt, ic_rdy, dc_rdy, ic_done, dc_done,
               l2_req, l2_addr, l2_cache_rw, arb_err
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_rdy, l2_complete,
        input  ic_gnt, dc_gnt, ic_rdy, dc_rdy, ic_done, dc_done,
               l2_req, l2_addr, l2_cache_rw, arb_err
    );
endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 cache port between the icache and dcache controllers.
// One requester is granted at a time; the grant is held until L2 signals l2_complete.
// Ties are resolved round-robin, and a watchdog aborts a grant that never completes.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous, active-low reset
//   bus   - l2_arbiter_if.slave: ic/dc requests, L2 status, grants, L2 request/address,
//           routed rdy/done strobes and the sticky arb_err flag
module l2_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input logic         clk,
    input logic         reset,
    l2_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StGrantIc, StGrantDc, StRelease} state_e;

    localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_dc_q, last_dc_d;  // 1: dcache was the last owner
    logic              ic_gnt_q, ic_gnt_d;
    logic              dc_gnt_q, dc_gnt_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              pick_dc, pick_ic;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            last_dc_q <= 1'b0;
            ic_gnt_q  <= 1'b0;
            dc_gnt_q  <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_dc_q <= last_dc_d;
            ic_gnt_q  <= ic_gnt_d;
            dc_gnt_q  <= dc_gnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_dc_d = last_dc_q;
        ic_gnt_d  = ic_gnt_q;
        dc_gnt_d  = dc_gnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        err_d     = err_q;
        wd_d      = '0;
        // dcache wins unless both request and it owned the port last
        pick_dc   = bus.dc_req && (!bus.ic_req || !last_dc_q);
        pick_ic   = bus.ic_req && !pick_dc;

        unique case (state_q)
            StIdle: begin
                if (!bus.l2_busy) begin
                    if (pick_dc) begin
                        state_d  = StGrantDc;
                        dc_gnt_d = 1'b1;
                        req_d    = 1'b1;
                        addr_d   = bus.dc_addr;
                        rw_d     = bus.dc_rw;
                    end else if (pick_ic) begin
                        state_d  = StGrantIc;
                        ic_gnt_d = 1'b1;
                        req_d    = 1'b1;
                        addr_d   = bus.ic_addr;
                        rw_d     = 1'b0;
                    end
                end
            end
            StGrantIc, StGrantDc: begin
                wd_d = wd_q + 1'b1;
                // completion takes priority over a coincident watchdog expiry
                if (bus.l2_complete || wd_q == WdLast) begin
                    state_d   = StRelease;
                    ic_gnt_d  = 1'b0;
                    dc_gnt_d  = 1'b0;
                    req_d     = 1'b0;
                    wd_d      = '0;
                    last_dc_d = (state_q == StGrantDc);
                    if (!bus.l2_complete) begin
                        err_d = 1'b1;
                    end
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ic_gnt      = ic_gnt_q;
    assign bus.dc_gnt      = dc_gnt_q;
    assign bus.l2_req      = req_q;
    assign bus.l2_addr     = addr_q;
    assign bus.l2_cache_rw = rw_q;
    assign bus.arb_err     = err_q;
    assign bus.ic_rdy      = bus.l2_rdy & ic_gnt_q;
    assign bus.dc_rdy      = bus.l2_rdy & dc_gnt_q;
    assign bus.ic_done     = bus.l2_complete & ic_gnt_q;
    assign bus.dc_done     = bus.l2_complete & dc_gnt_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed self-checking bench for l2_arbiter (TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after an input change for the combinational strobes.
module tb_l2_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    l2_arbiter_if #(.ADDR_W(32)) bus ();

    l2_arbiter #(
        .ADDR_W (32),
        .TIMEOUT(8),
        .TO_W   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [8:0] flags();
        return {bus.ic_gnt, bus.dc_gnt, bus.l2_req, bus.l2_cache_rw, bus.arb_err,
                bus.ic_rdy, bus.dc_rdy, bus.ic_done, bus.dc_done};
    endfunction

    task automatic drive_idle();
        bus.ic_req = 1'b0; bus.ic_addr = '0; bus.dc_req = 1'b0; bus.dc_addr = '0;
        bus.dc_rw = 1'b0; bus.l2_busy = 1'b0; bus.l2_rdy = 1'b0; bus.l2_complete = 1'b0;
    endtask

    // Waits (bounded) for any grant; returns falling edges waited, 99 on expiry.
    task automatic wait_gnt(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(bus.ic_gnt || bus.dc_gnt) && cycles < 20);
        if (!(bus.ic_gnt || bus.dc_gnt)) cycles = 99;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ic_req = $urandom_range(0, 1); bus.dc_req = $urandom_range(0, 1);
            bus.ic_addr = $urandom; bus.dc_addr = $urandom; bus.dc_rw = $urandom_range(0, 1);
            bus.l2_busy = $urandom_range(0, 1); bus.l2_rdy = 1'b1; bus.l2_complete = 1'b1;
            #1;
            vectors++;
            if (flags() !== 9'd0 || bus.l2_addr !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_held: flags=%b addr=%h want 0/0", flags(), bus.l2_addr);
            end
        end
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (flags() !== 9'd0 || bus.l2_addr !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_idle: flags=%b addr=%h want 0/0", flags(), bus.l2_addr);
            end
        end
    endtask

    task automatic test_ic_single();
        @(negedge clk);
        bus.ic_req = 1'b1; bus.ic_addr = 32'h1000_0040; bus.dc_addr = 32'hdead_beef;
        bus.dc_rw = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.ic_gnt, bus.dc_gnt, bus.l2_req, bus.l2_cache_rw} !== 4'b1010
            || bus.l2_addr !== 32'h1000_0040) begin
            miscompares++;
            $display("FAIL ic_grant: gnt/req/rw=%b addr=%h want 1010 10000040",
                     {bus.ic_gnt, bus.dc_gnt, bus.l2_req, bus.l2_cache_rw}, bus.l2_addr);
        end
        // request drop and address change must be ignored during the grant
        bus.ic_req = 1'b0; bus.ic_addr = 32'h5555_0000; bus.l2_rdy = 1'b1;
        #1;
        vectors++;
        if ({bus.ic_rdy, bus.dc_rdy, bus.ic_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL ic_rdy: rdy/dcrdy/done=%b want 100",
                     {bus.ic_rdy, bus.dc_rdy, bus.ic_done});
        end
        @(negedge clk);
        bus.l2_rdy = 1'b0; bus.l2_complete = 1'b1;
        #1;
        vectors++;
        if ({bus.ic_done, bus.dc_done, bus.ic_gnt} !== 3'b101 || bus.l2_addr !== 32'h1000_0040)
        begin
            miscompares++;
            $display("FAIL ic_done: done/dcdone/gnt=%b addr=%h want 101 10000040",
                     {bus.ic_done, bus.dc_done, bus.ic_gnt}, bus.l2_addr);
        end
        @(negedge clk);
        bus.l2_complete = 1'b0;
        vectors++;
        if ({bus.ic_gnt, bus.l2_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL ic_release: gnt/req=%b want 00", {bus.ic_gnt, bus.l2_req});
        end
        // L2 strobes outside a grant are not routed
        bus.l2_rdy = 1'b1; bus.l2_complete = 1'b1;
        #1;
        vectors++;
        if ({bus.ic_rdy, bus.dc_rdy, bus.ic_done, bus.dc_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL no_route: rdy/done=%b want 0000",
                     {bus.ic_rdy, bus.dc_rdy, bus.ic_done, bus.dc_done});
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int cyc;
        logic exp_dc;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1; bus.dc_rw = 1'b1;
        bus.ic_addr = 32'h1111_0000; bus.dc_addr = 32'h2222_0000;
        for (int r = 0; r < 4; r++) begin
            exp_dc = (r % 2 == 0);
            wait_gnt(cyc);
            vectors++;
            if (cyc != ((r == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr_latency[%0d]: waited %0d want %0d", r, cyc, (r == 0) ? 1 : 2);
            end
            vectors++;
            if ({bus.dc_gnt, bus.ic_gnt, bus.l2_cache_rw} !== {exp_dc, !exp_dc, exp_dc}
                || bus.l2_addr !== (exp_dc ? 32'h2222_0000 : 32'h1111_0000)) begin
                miscompares++;
                $display("FAIL rr_owner[%0d]: dc/ic/rw=%b addr=%h want %b", r,
                         {bus.dc_gnt, bus.ic_gnt, bus.l2_cache_rw}, bus.l2_addr,
                         {exp_dc, !exp_dc, exp_dc});
            end
            bus.l2_complete = 1'b1;
            @(negedge clk);
            bus.l2_complete = 1'b0;
            vectors++;
            if ({bus.dc_gnt, bus.ic_gnt} !== 2'b00) begin
                miscompares++;
                $display("FAIL rr_release[%0d]: dc/ic=%b want 00", r, {bus.dc_gnt, bus.ic_gnt});
            end
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_busy();
        @(negedge clk);
        bus.l2_busy = 1'b1; bus.dc_req = 1'b1; bus.dc_rw = 1'b1; bus.dc_addr = 32'h2000_0080;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.dc_gnt, bus.ic_gnt, bus.l2_req} !== 3'b000) begin
                miscompares++;
                $display("FAIL busy_hold[%0d]: gnt/req=%b want 000", i,
                         {bus.dc_gnt, bus.ic_gnt, bus.l2_req});
            end
        end
        bus.l2_busy = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.dc_gnt, bus.l2_req, bus.l2_cache_rw} !== 3'b111
            || bus.l2_addr !== 32'h2000_0080) begin
            miscompares++;
            $display("FAIL busy_grant: gnt/req/rw=%b addr=%h want 111 20000080",
                     {bus.dc_gnt, bus.l2_req, bus.l2_cache_rw}, bus.l2_addr);
        end
        bus.dc_req = 1'b0; bus.l2_complete = 1'b1;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        int high;
        bus.dc_req = 1'b1; bus.dc_addr = 32'h3000_0000;
        wait_gnt(cyc);
        bus.dc_req = 1'b0;
        vectors++;
        if (cyc != 1 || bus.dc_gnt !== 1'b1 || bus.arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_start: waited %0d gnt=%b err=%b want 1/1/0",
                     cyc, bus.dc_gnt, bus.arb_err);
        end
        high = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.dc_gnt) break;
            high++;
            vectors++;
            if (bus.dc_done !== 1'b0) begin
                miscompares++;
                $display("FAIL to_nodone: dc_done=%b want 0", bus.dc_done);
            end
        end
        vectors++;
        if (high != 8 || bus.arb_err !== 1'b1 || bus.dc_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL to_expire: grant cycles %0d err=%b gnt=%b want 8/1/0",
                     high, bus.arb_err, bus.dc_gnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.arb_err !== 1'b1 || bus.dc_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL to_sticky[%0d]: err=%b gnt=%b want 1/0", i, bus.arb_err, bus.dc_gnt);
            end
        end
    endtask

    task automatic test_complete_at_timeout();
        int cyc;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (bus.arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: arb_err=%b want 0", bus.arb_err);
        end
        bus.dc_req = 1'b1; bus.dc_addr = 32'h4000_0000;
        wait_gnt(cyc);
        bus.dc_req = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.dc_gnt !== 1'b1) begin
                miscompares++;
                $display("FAIL edge_hold[%0d]: dc_gnt=%b want 1", k, bus.dc_gnt);
            end
        end
        bus.l2_complete = 1'b1;
        #1;
        vectors++;
        if (bus.dc_done !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_done: dc_done=%b want 1", bus.dc_done);
        end
        @(negedge clk);
        bus.l2_complete = 1'b0;
        vectors++;
        if (bus.dc_gnt !== 1'b0 || bus.arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_err: gnt=%b err=%b want 0/0", bus.dc_gnt, bus.arb_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h5000_0010;
        wait_gnt(cyc);
        bus.ic_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.ic_gnt !== 1'b1 || cyc != 1) begin
            miscompares++;
            $display("FAIL mid_pre: ic_gnt=%b waited %0d want 1/1", bus.ic_gnt, cyc);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.ic_gnt, bus.l2_req} !== 2'b00 || bus.l2_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: gnt/req=%b addr=%h want 00 0",
                     {bus.ic_gnt, bus.l2_req}, bus.l2_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.ic_gnt, bus.dc_gnt, bus.l2_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_after: gnt/req=%b want 000", {bus.ic_gnt, bus.dc_gnt, bus.l2_req});
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_ic_single();
        test_round_robin();
        test_busy();
        test_timeout();
        test_complete_at_timeout();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
